// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and memory.
//   IMEM_REQ   : fetch request (fetch -> memory)
//   IMEM_ADDR  : word address of the request (fetch -> memory)
//   IMEM_ACK   : data returned this cycle, meaningful only while IMEM_REQ=1 (memory -> fetch)
//   IMEM_RDATA : returned instruction word (memory -> fetch)
interface instruction_fetch_if #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned INSTR_WIDTH = 16
);
    logic                   IMEM_REQ;
    logic [ADDR_WIDTH-1:0]  IMEM_ADDR;
    logic                   IMEM_ACK;
    logic [INSTR_WIDTH-1:0] IMEM_RDATA;

    modport master (
        output IMEM_REQ,
        output IMEM_ADDR,
        input  IMEM_ACK,
        input  IMEM_RDATA
    );

    modport slave (
        input  IMEM_REQ,
        input  IMEM_ADDR,
        output IMEM_ACK,
        output IMEM_RDATA
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, fetches words over the imem req/ack bus, latches them
// into the instruction register and picks the next PC from BRANCH/ZERO/HALT.
//   CLK, RST_N  : clock, synchronous active-low reset
//   imem        : instruction-memory bus (master side)
//   STALL       : downstream hold, freezes the ISSUE state
//   BRANCH/ZERO : taken-branch condition for the issued instruction
//   HALT        : stop the core (priority over BRANCH)
//   INSTR       : instruction register; OPCODE is its top 4 bits
//   PC_OUT      : address of the instruction in INSTR
//   INSTR_VALID : INSTR holds a live instruction
//   HALTED      : core stopped until reset
module instruction_fetch #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned INSTR_WIDTH = 16,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    instruction_fetch_if.master    imem,
    input  logic                   STALL,
    input  logic                   BRANCH,
    input  logic                   ZERO,
    input  logic                   HALT,
    output logic [INSTR_WIDTH-1:0] INSTR,
    output logic [3:0]             OPCODE,
    output logic [ADDR_WIDTH-1:0]  PC_OUT,
    output logic                   INSTR_VALID,
    output logic                   HALTED
);
    localparam int unsigned OPC_W = 4;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_ISSUE  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [ADDR_WIDTH-1:0]  pc, pc_nxt, pc_out_nxt;
    logic [INSTR_WIDTH-1:0] instr_nxt;
    logic                   req, req_nxt;
    logic                   valid_nxt, halted_nxt;

    logic signed [7:0]      ofs;
    logic [ADDR_WIDTH-1:0]  ofs_ext;
    logic [ADDR_WIDTH-1:0]  pc_inc;

    // Branch offset sign-extended (or truncated) to the PC width; all PC math wraps.
    assign ofs     = signed'(INSTR[7:0]);
    assign ofs_ext = ADDR_WIDTH'(ofs);
    assign pc_inc  = pc + ADDR_WIDTH'(1);

    assign imem.IMEM_REQ  = req;
    assign imem.IMEM_ADDR = pc;
    assign OPCODE         = INSTR[INSTR_WIDTH-1 -: OPC_W];

    // Next-state and next-register values.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        instr_nxt  = INSTR;
        pc_out_nxt = PC_OUT;
        case (state)
            S_FETCH: begin
                // The first cycle after reset has req=0, so an ACK there is ignored.
                if (req && imem.IMEM_ACK) begin
                    instr_nxt  = imem.IMEM_RDATA;
                    pc_out_nxt = pc;
                    state_nxt  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!STALL) begin
                    if (HALT) begin
                        state_nxt = S_HALTED;
                    end else begin
                        state_nxt = S_FETCH;
                        pc_nxt    = (BRANCH && ZERO) ? pc_inc + ofs_ext : pc_inc;
                    end
                end
            end
            S_HALTED: begin
                state_nxt = S_HALTED;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
        req_nxt    = (state_nxt == S_FETCH);
        valid_nxt  = (state_nxt == S_ISSUE);
        halted_nxt = (state_nxt == S_HALTED);
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= S_FETCH;
            pc          <= ADDR_WIDTH'(RESET_PC);
            PC_OUT      <= ADDR_WIDTH'(RESET_PC);
            INSTR       <= '0;
            req         <= 1'b0;
            INSTR_VALID <= 1'b0;
            HALTED      <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            PC_OUT      <= pc_out_nxt;
            INSTR       <= instr_nxt;
            req         <= req_nxt;
            INSTR_VALID <= valid_nxt;
            HALTED      <= halted_nxt;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for the fetch stage: reset, handshake latency, branches, stall,
// halt, PC wrap and reset during an outstanding fetch.
module tb_instruction_fetch;
    localparam int unsigned AW = 8;
    localparam int unsigned IW = 16;

    logic          CLK;
    logic          RST_N;
    logic          STALL, BRANCH, ZERO, HALT;
    logic [IW-1:0] INSTR;
    logic [3:0]    OPCODE;
    logic [AW-1:0] PC_OUT;
    logic          INSTR_VALID, HALTED;

    int checks = 0;
    int errors = 0;

    instruction_fetch_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) imem ();

    instruction_fetch #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(0)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .imem        (imem.master),
        .STALL       (STALL),
        .BRANCH      (BRANCH),
        .ZERO        (ZERO),
        .HALT        (HALT),
        .INSTR       (INSTR),
        .OPCODE      (OPCODE),
        .PC_OUT      (PC_OUT),
        .INSTR_VALID (INSTR_VALID),
        .HALTED      (HALTED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Zero-wait fetch: ACK for one cycle, leaves the DUT in ISSUE.
    task automatic fetch(input logic [IW-1:0] word);
        imem.IMEM_ACK   = 1'b1;
        imem.IMEM_RDATA = word;
        tick();
        imem.IMEM_ACK   = 1'b0;
    endtask

    // One non-stalled ISSUE cycle with the given control inputs.
    task automatic issue(input logic br, input logic z, input logic h);
        BRANCH = br;
        ZERO   = z;
        HALT   = h;
        tick();
        BRANCH = 1'b0;
        ZERO   = 1'b0;
        HALT   = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0;
        STALL = 1'b0; BRANCH = 1'b0; ZERO = 1'b0; HALT = 1'b0;
        imem.IMEM_ACK = 1'b0;
        imem.IMEM_RDATA = '0;

        // 1: reset for two cycles, then first request at address 0
        tick(); tick();
        chk("rst_req",    32'(imem.IMEM_REQ), 32'd0);
        chk("rst_valid",  32'(INSTR_VALID),   32'd0);
        chk("rst_halted", 32'(HALTED),        32'd0);
        chk("rst_opcode", 32'(OPCODE),        32'd0);
        chk("rst_instr",  32'(INSTR),         32'd0);
        RST_N = 1'b1;
        tick();
        chk("first_req",  32'(imem.IMEM_REQ),  32'd1);
        chk("first_addr", 32'(imem.IMEM_ADDR), 32'h00);

        // 2: two wait cycles then ACK with 0x1234
        tick(); tick();
        chk("wait_req", 32'(imem.IMEM_REQ), 32'd1);
        fetch(16'h1234);
        chk("t2_instr",  32'(INSTR),          32'h1234);
        chk("t2_opcode", 32'(OPCODE),         32'h1);
        chk("t2_pcout",  32'(PC_OUT),         32'h00);
        chk("t2_valid",  32'(INSTR_VALID),    32'd1);
        chk("t2_req",    32'(imem.IMEM_REQ),  32'd0);
        issue(1'b0, 1'b0, 1'b0);
        chk("t2_valid_drop", 32'(INSTR_VALID),    32'd0);
        chk("t2_next_req",   32'(imem.IMEM_REQ),  32'd1);
        chk("t2_next_addr",  32'(imem.IMEM_ADDR), 32'h01);

        // 3: advance to PC=5, taken branch by -4, then not-taken
        for (int i = 0; i < 4; i++) begin
            fetch(16'h0000);
            issue(1'b0, 1'b0, 1'b0);
        end
        chk("t3_addr5", 32'(imem.IMEM_ADDR), 32'h05);
        fetch(16'h20FC);
        chk("t3_pcout", 32'(PC_OUT), 32'h05);
        issue(1'b1, 1'b1, 1'b0);
        chk("t3_taken", 32'(imem.IMEM_ADDR), 32'h02);
        for (int i = 0; i < 3; i++) begin
            fetch(16'h0000);
            issue(1'b0, 1'b0, 1'b0);
        end
        fetch(16'h20FC);
        issue(1'b1, 1'b0, 1'b0);
        chk("t3_nottaken", 32'(imem.IMEM_ADDR), 32'h06);

        // 4: stall three cycles with a spurious ACK of 0xFFFF
        fetch(16'h3001);
        STALL = 1'b1;
        imem.IMEM_ACK = 1'b1;
        imem.IMEM_RDATA = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_valid", 32'(INSTR_VALID),    32'd1);
            chk("t4_instr", 32'(INSTR),          32'h3001);
            chk("t4_req",   32'(imem.IMEM_REQ),  32'd0);
            chk("t4_pc",    32'(imem.IMEM_ADDR), 32'h06);
            chk("t4_pcout", 32'(PC_OUT),         32'h06);
        end
        STALL = 1'b0;
        imem.IMEM_ACK = 1'b0;
        tick();
        chk("t4_after_addr", 32'(imem.IMEM_ADDR), 32'h07);
        chk("t4_after_req",  32'(imem.IMEM_REQ),  32'd1);

        // 5: HALT beats BRANCH; stays halted under toggling ACK; reset recovers
        fetch(16'hF0FC);
        issue(1'b1, 1'b1, 1'b1);
        chk("t5_halted", 32'(HALTED),         32'd1);
        chk("t5_valid",  32'(INSTR_VALID),    32'd0);
        chk("t5_req",    32'(imem.IMEM_REQ),  32'd0);
        for (int i = 0; i < 20; i++) begin
            imem.IMEM_ACK   = ~imem.IMEM_ACK;
            imem.IMEM_RDATA = 16'hBEEF;
            tick();
            chk("t5_hold_req",    32'(imem.IMEM_REQ), 32'd0);
            chk("t5_hold_halted", 32'(HALTED),        32'd1);
            chk("t5_hold_instr",  32'(INSTR),         32'hF0FC);
        end
        imem.IMEM_ACK = 1'b0;
        RST_N = 1'b0;
        tick();
        chk("t5_rst_halted", 32'(HALTED), 32'd0);
        RST_N = 1'b1;
        tick();
        chk("t5_resume_req",  32'(imem.IMEM_REQ),  32'd1);
        chk("t5_resume_addr", 32'(imem.IMEM_ADDR), 32'h00);

        // 6a: branch 0 -> 0xFE (offset -3), then to 0xFF, then wrap to 0x00
        fetch(16'h20FD);
        issue(1'b1, 1'b1, 1'b0);
        chk("t6_neg_wrap", 32'(imem.IMEM_ADDR), 32'hFE);
        fetch(16'h0000);
        issue(1'b0, 1'b0, 1'b0);
        chk("t6_addr_ff", 32'(imem.IMEM_ADDR), 32'hFF);
        fetch(16'h1111);
        chk("t6_pcout_ff", 32'(PC_OUT), 32'hFF);
        issue(1'b0, 1'b0, 1'b0);
        chk("t6_wrap", 32'(imem.IMEM_ADDR), 32'h00);

        // 6b: reset while REQ=1 and ACK arrives; ACK still high on release cycle
        chk("t6_req_before", 32'(imem.IMEM_REQ), 32'd1);
        RST_N = 1'b0;
        imem.IMEM_ACK = 1'b1;
        imem.IMEM_RDATA = 16'hABCD;
        tick();
        chk("t6_rst_instr", 32'(INSTR),         32'h0000);
        chk("t6_rst_valid", 32'(INSTR_VALID),   32'd0);
        chk("t6_rst_req",   32'(imem.IMEM_REQ), 32'd0);
        RST_N = 1'b1;
        tick();
        imem.IMEM_ACK = 1'b0;
        chk("t6_rel_instr", 32'(INSTR),          32'h0000);
        chk("t6_rel_valid", 32'(INSTR_VALID),    32'd0);
        chk("t6_rel_req",   32'(imem.IMEM_REQ),  32'd1);
        chk("t6_rel_addr",  32'(imem.IMEM_ADDR), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage of basic_processor. Holds the PC and issues word requests to instruction memory over a req/ack handshake. Latches each returned word into the instruction register and presents OPCODE to the Control decoder. Uses Control's BRANCH and HALT plus the ALU ZERO flag to pick the next PC.

Parameters:
ADDR_WIDTH, 8, PC / instruction-memory word-address width
INSTR_WIDTH, 16, instruction width; OPCODE = INSTR[INSTR_WIDTH-1 -: 4], branch offset = INSTR[7:0]
RESET_PC, 0, PC value loaded on reset

Ports:
CLK  in  1  clock; all state changes on its rising edge
RST_N  in  1  synchronous reset, active low
IMEM_REQ  out  1  fetch request to instruction memory
IMEM_ADDR  out  ADDR_WIDTH  word address for the request; equals PC
IMEM_ACK  in  1  memory has returned data; valid only while IMEM_REQ=1
IMEM_RDATA  in  INSTR_WIDTH  instruction word; sampled when IMEM_REQ && IMEM_ACK
STALL  in  1  downstream hold; freezes the ISSUE state
BRANCH  in  1  from Control; branch instruction in ISSUE
ZERO  in  1  ALU zero flag for the issued instruction
HALT  in  1  from Control; halt instruction in ISSUE
INSTR  out  INSTR_WIDTH  instruction register
OPCODE  out  4  INSTR[INSTR_WIDTH-1 -: 4]; drives Control.OPCODE
PC_OUT  out  ADDR_WIDTH  address of the instruction in INSTR
INSTR_VALID  out  1  INSTR/OPCODE hold a live instruction
HALTED  out  1  core stopped

Behaviour:
- Reset: when RST_N=0 at a rising edge, the following values load regardless of state.
  - PC=RESET_PC, INSTR=0, OPCODE=0, IMEM_REQ=0, INSTR_VALID=0, HALTED=0.
  - State goes to FETCH.
  - Reset applied mid-fetch abandons the request; any pending ACK is ignored.
- FSM states:
  - FETCH: IMEM_REQ=1 and IMEM_ADDR=PC, both registered. The first cycle after reset release is the first REQ cycle. IMEM_ACK is sampled each cycle.
    - When ACK=1: INSTR<=IMEM_RDATA, PC_OUT<=PC, IMEM_REQ<=0, INSTR_VALID<=1, next state ISSUE.
    - ACK latency is unbounded; wait indefinitely.
  - ISSUE: INSTR_VALID=1, IMEM_REQ=0.
    - STALL=1: hold INSTR and PC and stay in ISSUE.
    - STALL=0 and HALT=1: next state HALTED, INSTR_VALID<=0. HALT has priority over BRANCH.
    - STALL=0, HALT=0, BRANCH=1, ZERO=1: PC<=PC+1+sext(INSTR[7:0]), next state FETCH, INSTR_VALID<=0.
    - STALL=0, HALT=0, otherwise: PC<=PC+1, next state FETCH, INSTR_VALID<=0.
  - HALTED: IMEM_REQ=0, INSTR_VALID=0, HALTED=1. Leaves this state only via reset.
- Arithmetic:
  - All PC math is modulo 2^ADDR_WIDTH, so 0xFF+1 wraps to 0x00.
  - The offset is sign-extended (or truncated) to ADDR_WIDTH before the add.
- IMEM_ACK while IMEM_REQ=0 (in ISSUE or HALTED) is ignored; INSTR is unchanged.
- Throughput: at most one instruction every 2 cycles (zero-wait ACK plus a non-stalled ISSUE).
- OPCODE is a combinational slice of INSTR, so Control outputs settle within the ISSUE cycle.

Test Plan:
1. RST_N=0 for 2 cycles, then 1 -> during reset REQ=0, VALID=0, HALTED=0, OPCODE=0. First edge after release: REQ=1, ADDR=0x00.
2. ACK after 2 wait cycles with RDATA=16'h1234 -> INSTR=0x1234, OPCODE=4'h1, PC_OUT=0x00, VALID=1 for one cycle (STALL=0). Then REQ=1 with ADDR=0x01.
3. Branch at PC=0x05 with INSTR[7:0]=8'hFC:
   - BRANCH=1, ZERO=1 -> next ADDR=0x02.
   - Repeat with ZERO=0 -> next ADDR=0x06.
4. STALL=1 for 3 cycles in ISSUE, with a spurious ACK and RDATA=16'hFFFF -> VALID held, INSTR unchanged, REQ=0, PC unchanged. After STALL drops, ADDR=PC+1.
5. HALT=1 together with BRANCH=1, ZERO=1 in ISSUE -> HALTED=1 next cycle and REQ stays 0 for 20 cycles with ACK toggling. Pulse RST_N -> fetch resumes at ADDR=0x00.
6. Two cases:
   - Instruction at PC=0xFF, non-branch -> next ADDR=0x00.
   - RST_N=0 while REQ=1 and ACK is arriving -> INSTR stays 0, VALID=0, and fetch restarts at 0x00.
